// File: rtl/fft_pkg.sv
// Shared definitions for the iterative radix-2 FFT core.
//   fft_state_e : controller states (LOAD, COMPUTE, UNLOAD)
//   clog2       : ceiling log2 usable in parameter and port declarations
//   bitrev      : reverses the low 'bits' bits of a 16-bit value
// The complex sample type depends on the instance data width, so it is
// declared inside fft_iter_r2 from its DW parameter.
package fft_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    UNLOAD  = 2'd2
  } fft_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [15:0] bitrev(input logic [15:0] value, input int bits);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < bits) r[i] = value[bits-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Combinational twiddle table W^k = cos(2*pi*k/N) - j*sin(2*pi*k/N),
// k = 0..N/2-1, quantised round-to-nearest to signed Q1.(TW-1). The value
// +1.0 is not representable and saturates to 2^(TW-1)-1.
// Ports:
//   k    in  log2(N)-1 bits  twiddle index
//   w_re out TW bits         real part, signed
//   w_im out TW bits         imaginary part, signed
module fft_twiddle_rom
  import fft_pkg::*;
#(
  parameter int N_PTS = 8,
  parameter int TW    = 16
) (
  input  logic [clog2(N_PTS)-2:0] k,
  output logic signed [TW-1:0]    w_re,
  output logic signed [TW-1:0]    w_im
);

  localparam real PI = 3.14159265358979323846;

  function automatic logic signed [TW-1:0] quant(input real v);
    real s;
    int  q;
    int  q_max;
    int  q_min;
    s     = v * (2.0 ** (TW - 1));
    q_max = (1 << (TW - 1)) - 1;
    q_min = -(1 << (TW - 1));
    if (s >= 0.0) q = $rtoi(s + 0.5);
    else          q = -$rtoi(0.5 - s);
    if (q > q_max) q = q_max;
    if (q < q_min) q = q_min;
    return q[TW-1:0];
  endfunction

  logic signed [TW-1:0] w_tab_re [N_PTS/2];
  logic signed [TW-1:0] w_tab_im [N_PTS/2];

  for (genvar g = 0; g < N_PTS / 2; g++) begin : g_tab
    localparam real ANG = 2.0 * PI * real'(g) / real'(N_PTS);
    assign w_tab_re[g] = quant($cos(ANG));
    assign w_tab_im[g] = quant(-$sin(ANG));
  end

  assign w_re = w_tab_re[k];
  assign w_im = w_tab_im[k];

endmodule

// File: rtl/fft_iter_r2.sv
// Iterative radix-2 decimation-in-time FFT with one shared butterfly.
// Samples arrive on a valid/ready stream and are stored bit-reversed; the
// frame is transformed in place over log2(N) stages (one butterfly per
// cycle) and the bins stream out in natural order, scaled by 1/N.
// Handshake: a transfer happens on a clock edge where valid && ready; the
// producer holds data stable while valid is high and ready is low.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      input sample handshake (ready only in LOAD)
//   in_re, in_im           input sample, signed DW bits each
//   out_valid/out_ready    output bin handshake
//   out_re, out_im         output bin, signed DW bits each
//   out_idx                bin index of the current output
//   busy                   high during COMPUTE and UNLOAD
module fft_iter_r2
  import fft_pkg::*;
#(
  parameter int N_PTS = 8,
  parameter int DW    = 16,
  parameter int TW    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DW-1:0]    in_re,
  input  logic signed [DW-1:0]    in_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [DW-1:0]    out_re,
  output logic signed [DW-1:0]    out_im,
  output logic [clog2(N_PTS)-1:0] out_idx,
  output logic                    busy
);

  localparam int LOG2N = clog2(N_PTS);
  localparam int KW    = LOG2N - 1;
  localparam int SW    = clog2(LOG2N) + 1;
  localparam int MW    = (DW > TW) ? DW : TW;
  localparam int PW    = 2 * MW + 1;
  localparam int SDW   = DW + 2;
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N_PTS - 1);

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  fft_state_e       r_state;
  fft_state_e       w_state_nxt;
  logic [LOG2N-1:0] r_cnt;        // sample index in LOAD, bin index in UNLOAD
  logic [KW-1:0]    r_bfly;       // butterfly j within the stage
  logic [SW-1:0]    r_stage;
  logic             r_out_valid;
  cplx_t            r_out;
  logic [LOG2N-1:0] r_out_idx;
  cplx_t            r_buf [N_PTS];

  logic             w_accept;
  logic             w_last_bfly;
  logic             w_last_out;
  logic [LOG2N-1:0] w_cnt_inc;
  logic [LOG2N-1:0] w_wr_addr;
  logic [LOG2N-1:0] w_j;
  logic [LOG2N-1:0] w_pos;
  logic [LOG2N-1:0] w_grp;
  logic [LOG2N-1:0] w_a;
  logic [LOG2N-1:0] w_b;
  logic [LOG2N-1:0] w_tk_full;
  logic [KW-1:0]    w_tk;
  logic signed [TW-1:0] w_tw_re;
  logic signed [TW-1:0] w_tw_im;
  cplx_t            w_opa;
  cplx_t            w_opb;
  cplx_t            w_in;
  cplx_t            w_resa;
  cplx_t            w_resb;

  logic signed [PW-1:0]  w_bre_x, w_bim_x, w_wre_x, w_wim_x;
  logic signed [PW-1:0]  w_tre_full, w_tim_full;
  logic signed [SDW-1:0] w_tre, w_tim, w_are_x, w_aim_x;
  logic signed [SDW-1:0] w_sum_re, w_sum_im, w_dif_re, w_dif_im;

  assign w_accept    = (r_state == LOAD) && in_valid;
  assign w_last_bfly = (&r_bfly) && (r_stage == SW'(LOG2N - 1));
  assign w_last_out  = r_out_valid && out_ready && (r_cnt == LAST_IDX);
  assign w_cnt_inc   = r_cnt + LOG2N'(1);
  assign w_wr_addr   = LOG2N'(bitrev(16'(r_cnt), LOG2N));

  // Next-state and status outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    case (r_state)
      LOAD: begin
        in_ready = 1'b1;
        if (w_accept && (r_cnt == LAST_IDX)) w_state_nxt = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (w_last_bfly) w_state_nxt = UNLOAD;
      end
      UNLOAD: begin
        busy = 1'b1;
        if (w_last_out) w_state_nxt = LOAD;
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  // Butterfly addressing: half = 2^s, a = grp*2*half + pos, b = a + half,
  // twiddle k = pos * N/(2*half) = pos << (log2(N)-1-s).
  always_comb begin
    w_j       = {1'b0, r_bfly};
    w_pos     = w_j & ((LOG2N'(1) << r_stage) - LOG2N'(1));
    w_grp     = w_j >> r_stage;
    w_a       = (w_grp << (r_stage + SW'(1))) | w_pos;
    w_b       = w_a | (LOG2N'(1) << r_stage);
    w_tk_full = w_pos << (SW'(KW) - r_stage);
    w_tk      = KW'(w_tk_full);
  end

  fft_twiddle_rom #(
    .N_PTS (N_PTS),
    .TW    (TW)
  ) u_twiddle (
    .k    (w_tk),
    .w_re (w_tw_re),
    .w_im (w_tw_im)
  );

  assign w_opa = r_buf[w_a];
  assign w_opb = r_buf[w_b];
  assign w_in  = '{re: in_re, im: in_im};

  // t = B*W at full precision, truncated by TW-1 fractional bits.
  assign w_bre_x    = {{(PW-DW){w_opb.re[DW-1]}}, w_opb.re};
  assign w_bim_x    = {{(PW-DW){w_opb.im[DW-1]}}, w_opb.im};
  assign w_wre_x    = {{(PW-TW){w_tw_re[TW-1]}}, w_tw_re};
  assign w_wim_x    = {{(PW-TW){w_tw_im[TW-1]}}, w_tw_im};
  assign w_tre_full = (w_bre_x * w_wre_x - w_bim_x * w_wim_x) >>> (TW - 1);
  assign w_tim_full = (w_bre_x * w_wim_x + w_bim_x * w_wre_x) >>> (TW - 1);
  assign w_tre      = SDW'(w_tre_full);
  assign w_tim      = SDW'(w_tim_full);

  // Halving every stage keeps the result in DW bits and gives 1/N overall.
  assign w_are_x  = {{2{w_opa.re[DW-1]}}, w_opa.re};
  assign w_aim_x  = {{2{w_opa.im[DW-1]}}, w_opa.im};
  assign w_sum_re = w_are_x + w_tre;
  assign w_sum_im = w_aim_x + w_tim;
  assign w_dif_re = w_are_x - w_tre;
  assign w_dif_im = w_aim_x - w_tim;
  assign w_resa.re = DW'(w_sum_re >>> 1);
  assign w_resa.im = DW'(w_sum_im >>> 1);
  assign w_resb.re = DW'(w_dif_re >>> 1);
  assign w_resb.im = DW'(w_dif_im >>> 1);

  // Sample buffer: contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[w_wr_addr] <= w_in;
    end else if (r_state == COMPUTE) begin
      r_buf[w_a] <= w_resa;
      r_buf[w_b] <= w_resb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LOAD;
      r_cnt       <= '0;
      r_bfly      <= '0;
      r_stage     <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_out_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        LOAD: begin
          if (w_accept) r_cnt <= w_cnt_inc;  // wraps to 0 after N-1
        end
        COMPUTE: begin
          r_bfly <= r_bfly + KW'(1);
          if (&r_bfly) r_stage <= w_last_bfly ? '0 : r_stage + SW'(1);
        end
        UNLOAD: begin
          // First UNLOAD cycle primes the output register from bin 0, which
          // lets the last butterfly write settle before it is read.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out       <= r_buf[r_cnt];
            r_out_idx   <= r_cnt;
          end else if (out_ready) begin
            if (r_cnt == LAST_IDX) begin
              r_out_valid <= 1'b0;
              r_cnt       <= '0;
            end else begin
              r_cnt     <= w_cnt_inc;
              r_out     <= r_buf[w_cnt_inc];
              r_out_idx <= w_cnt_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_re    = r_out.re;
  assign out_im    = r_out.im;
  assign out_idx   = r_out_idx;

endmodule
